pmem_arbiter: RTL and testbench

- Sits between the two memory requesters of the core (IFU instruction fetch, LSU load/store) and the single DPI-backed physical-memory port.
- Accepts one request at a time over valid/ready, then drives the memory port for a configurable number of cycles.
- Returns a registered response to the requester that owns the transaction.
- Write strobes are issued as single-cycle pulses with stable address/data/mask, so the combinational DPI write fires exactly once per store.

---
 rtl/pmem_arbiter_if.sv | 50 +++++
 rtl/pmem_arbiter.sv | 130 +++++++++++++
 tb/tb_pmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Requester, response and physical-memory signals of the IFU/LSU memory arbiter.
// The arbiter attaches through the slave modport; the master modport is the surrounding core and memory.
interface pmem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [63:0] ifu_resp_data;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [63:0] lsu_resp_data;

  logic        mem_rvalid;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic        mem_wvalid;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;

  logic        busy;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_rvalid, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
    output busy
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_rvalid, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wmask,
    input  busy
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one physical-memory port, one transaction at a time.
//   state  | meaning
//   IDLE   | arbitrating; the granted requester sees ready
//   ACCESS | driving the memory port for LAT cycles
//   RESP   | holding the owner's response until it is consumed
module pmem_arbiter #(
  parameter int unsigned LAT = 1,
  parameter bit          RR  = 1'b0
) (
  input logic           clock,
  input logic           reset,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        own_lsu;
  logic        wen_q;
  logic        rr_lsu;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] resp_q;
  logic [3:0]  cnt;
  logic        grant_ifu, grant_lsu;
  logic        last_beat;

  assign last_beat = (cnt == 4'(LAT - 1));

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (RR && bus.ifu_req_valid && bus.lsu_req_valid) begin
      grant_lsu = rr_lsu;
      grant_ifu = ~rr_lsu;
    end else if (bus.lsu_req_valid) begin
      grant_lsu = 1'b1;
    end else if (bus.ifu_req_valid) begin
      grant_ifu = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_data  = '0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_data  = '0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_raddr      = '0;
    bus.mem_wvalid     = 1'b0;
    bus.mem_waddr      = '0;
    bus.mem_wdata      = '0;
    bus.mem_wmask      = '0;
    bus.busy           = (state != IDLE);
    unique case (state)
      IDLE: begin
        // Readies are held low while reset is asserted so every output reads 0.
        bus.ifu_req_ready = grant_ifu & ~reset;
        bus.lsu_req_ready = grant_lsu & ~reset;
        if (grant_ifu | grant_lsu) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (wen_q) begin
          bus.mem_wvalid = (cnt == 4'd0);
          bus.mem_waddr  = addr_q;
          bus.mem_wdata  = wdata_q;
          bus.mem_wmask  = wmask_q;
        end else begin
          bus.mem_rvalid = 1'b1;
          bus.mem_raddr  = addr_q;
        end
        if (last_beat) state_nxt = RESP;
      end
      RESP: begin
        if (own_lsu) begin
          bus.lsu_resp_valid = 1'b1;
          bus.lsu_resp_data  = resp_q;
          if (bus.lsu_resp_ready) state_nxt = IDLE;
        end else begin
          bus.ifu_resp_valid = 1'b1;
          bus.ifu_resp_data  = resp_q;
          if (bus.ifu_resp_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_lsu <= 1'b0;
      wen_q   <= 1'b0;
      rr_lsu  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      resp_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ifu | grant_lsu) begin
            own_lsu <= grant_lsu;
            wen_q   <= grant_lsu & bus.lsu_req_wen;
            addr_q  <= grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
            wdata_q <= grant_lsu ? bus.lsu_req_wdata : 64'd0;
            wmask_q <= grant_lsu ? bus.lsu_req_wmask : 8'd0;
            rr_lsu  <= ~grant_lsu;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_beat) resp_q <= wen_q ? 64'd0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: two instances (LAT=1/fixed priority, LAT=3/round-robin) checked every cycle
// against a transaction-timing model, with directed scenarios followed by random traffic.
module tb_pmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  int          lat;
  bit          rr;

  logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_req_wen, lsu_resp_ready;
  logic [63:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;

  pmem_arbiter_if ifa ();
  pmem_arbiter_if ifb ();

  pmem_arbiter #(.LAT(1), .RR(1'b0)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  pmem_arbiter #(.LAT(3), .RR(1'b1)) dut_b (.clock(clock), .reset(reset), .bus(ifb));

  always #5 clock = ~clock;

  function automatic logic [63:0] mem_f(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00000413_00000297;
    return {a[31:0] ^ 32'hdead_beef, a[63:32] + a[31:0]};
  endfunction

  assign ifa.ifu_req_valid  = ~sel & ifu_req_valid;
  assign ifa.ifu_req_addr   = ifu_req_addr;
  assign ifa.ifu_resp_ready = ~sel & ifu_resp_ready;
  assign ifa.lsu_req_valid  = ~sel & lsu_req_valid;
  assign ifa.lsu_req_addr   = lsu_req_addr;
  assign ifa.lsu_req_wen    = lsu_req_wen;
  assign ifa.lsu_req_wdata  = lsu_req_wdata;
  assign ifa.lsu_req_wmask  = lsu_req_wmask;
  assign ifa.lsu_resp_ready = ~sel & lsu_resp_ready;
  assign ifa.mem_rdata      = mem_f(ifa.mem_raddr);

  assign ifb.ifu_req_valid  = sel & ifu_req_valid;
  assign ifb.ifu_req_addr   = ifu_req_addr;
  assign ifb.ifu_resp_ready = sel & ifu_resp_ready;
  assign ifb.lsu_req_valid  = sel & lsu_req_valid;
  assign ifb.lsu_req_addr   = lsu_req_addr;
  assign ifb.lsu_req_wen    = lsu_req_wen;
  assign ifb.lsu_req_wdata  = lsu_req_wdata;
  assign ifb.lsu_req_wmask  = lsu_req_wmask;
  assign ifb.lsu_resp_ready = sel & lsu_resp_ready;
  assign ifb.mem_rdata      = mem_f(ifb.mem_raddr);

  logic        o_ifu_req_ready, o_lsu_req_ready, o_ifu_resp_valid, o_lsu_resp_valid;
  logic        o_mem_rvalid, o_mem_wvalid, o_busy;
  logic [63:0] o_ifu_resp_data, o_lsu_resp_data, o_mem_raddr, o_mem_waddr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;

  assign o_ifu_req_ready  = sel ? ifb.ifu_req_ready  : ifa.ifu_req_ready;
  assign o_lsu_req_ready  = sel ? ifb.lsu_req_ready  : ifa.lsu_req_ready;
  assign o_ifu_resp_valid = sel ? ifb.ifu_resp_valid : ifa.ifu_resp_valid;
  assign o_lsu_resp_valid = sel ? ifb.lsu_resp_valid : ifa.lsu_resp_valid;
  assign o_ifu_resp_data  = sel ? ifb.ifu_resp_data  : ifa.ifu_resp_data;
  assign o_lsu_resp_data  = sel ? ifb.lsu_resp_data  : ifa.lsu_resp_data;
  assign o_mem_rvalid     = sel ? ifb.mem_rvalid     : ifa.mem_rvalid;
  assign o_mem_raddr      = sel ? ifb.mem_raddr      : ifa.mem_raddr;
  assign o_mem_wvalid     = sel ? ifb.mem_wvalid     : ifa.mem_wvalid;
  assign o_mem_waddr      = sel ? ifb.mem_waddr      : ifa.mem_waddr;
  assign o_mem_wdata      = sel ? ifb.mem_wdata      : ifa.mem_wdata;
  assign o_mem_wmask      = sel ? ifb.mem_wmask      : ifa.mem_wmask;
  assign o_busy           = sel ? ifb.busy           : ifa.busy;

  int checks = 0;
  int failures = 0;

  // Model: one outstanding transaction, accepted in cycle m_acc, occupying the port for
  // cycles m_acc+1..m_acc+lat and responding from m_acc+lat+1 until consumed.
  int          cyc = 0;
  bit          m_busy, m_owner_lsu, m_store, m_ptr_lsu;
  logic [63:0] m_addr, m_wdata, m_resp;
  logic [7:0]  m_wmask;
  int          m_acc;

  bit          last_hs_i, last_hs_l, prev_rv;
  int          hs_cyc, rv_cyc, wv_count, gn;
  logic [63:0] rv_data;
  logic [7:0]  gseq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic gi, gl, acc, rsp, st, rd, cons;
    int   k;
    #1;
    k  = cyc - m_acc;
    gi = 1'b0;
    gl = 1'b0;
    if (!m_busy && !reset) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (!rr || m_ptr_lsu) gl = 1'b1;
        else                  gi = 1'b1;
      end else if (lsu_req_valid) gl = 1'b1;
      else if (ifu_req_valid)     gi = 1'b1;
    end
    acc = m_busy && k >= 1 && k <= lat;
    rsp = m_busy && k > lat;
    st  = acc && m_store;
    rd  = acc && !m_store;
    chk("ifu_req_ready",  64'(o_ifu_req_ready),  64'(gi));
    chk("lsu_req_ready",  64'(o_lsu_req_ready),  64'(gl));
    chk("busy",           64'(o_busy),           64'(m_busy));
    chk("mem_rvalid",     64'(o_mem_rvalid),     64'(rd));
    chk("mem_raddr",      o_mem_raddr,           rd ? m_addr : 64'd0);
    chk("mem_wvalid",     64'(o_mem_wvalid),     64'(st && k == 1));
    chk("mem_waddr",      o_mem_waddr,           st ? m_addr : 64'd0);
    chk("mem_wdata",      o_mem_wdata,           st ? m_wdata : 64'd0);
    chk("mem_wmask",      64'(o_mem_wmask),      st ? 64'(m_wmask) : 64'd0);
    chk("ifu_resp_valid", 64'(o_ifu_resp_valid), 64'(rsp && !m_owner_lsu));
    chk("lsu_resp_valid", 64'(o_lsu_resp_valid), 64'(rsp && m_owner_lsu));
    if (rsp) chk("resp_data", m_owner_lsu ? o_lsu_resp_data : o_ifu_resp_data, m_resp);
    if (o_mem_wvalid) wv_count++;
    if ((o_ifu_resp_valid || o_lsu_resp_valid) && !prev_rv) begin
      rv_cyc  = cyc;
      rv_data = o_lsu_resp_valid ? o_lsu_resp_data : o_ifu_resp_data;
    end
    prev_rv   = o_ifu_resp_valid || o_lsu_resp_valid;
    last_hs_i = o_ifu_req_ready && ifu_req_valid;
    last_hs_l = o_lsu_req_ready && lsu_req_valid;
    cons      = rsp && (m_owner_lsu ? lsu_resp_ready : ifu_resp_ready);
    @(posedge clock);
    cyc++;
    if (cons) m_busy = 1'b0;
    if (gi || gl) begin
      m_busy      = 1'b1;
      m_acc       = cyc - 1;
      hs_cyc      = cyc - 1;
      m_owner_lsu = gl;
      m_store     = gl && lsu_req_wen;
      m_addr      = gl ? lsu_req_addr : ifu_req_addr;
      m_wdata     = lsu_req_wdata;
      m_wmask     = lsu_req_wmask;
      m_resp      = m_store ? 64'd0 : mem_f(m_addr);
      m_ptr_lsu   = !gl;
    end
    if (last_hs_i || last_hs_l) begin
      gseq = {gseq[6:0], last_hs_l};
      gn++;
    end
    #1;
  endtask

  task automatic run(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      step();
      if (last_hs_i) begin
        if (hold) ifu_req_addr = ifu_req_addr + 64'd4;
        else      ifu_req_valid = 1'b0;
      end
      if (last_hs_l) begin
        if (hold) lsu_req_addr = lsu_req_addr + 64'd8;
        else      lsu_req_valid = 1'b0;
      end
    end
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = {$urandom(), $urandom()};
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr  = {$urandom(), $urandom()};
        lsu_req_wen   = 1'($urandom_range(0, 1));
        lsu_req_wdata = {$urandom(), $urandom()};
        lsu_req_wmask = 8'($urandom());
      end
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
      run(1, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_wen    = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    m_busy    = 1'b0;
    m_ptr_lsu = 1'b1;
    gseq      = '0;
    gn        = 0;
    wv_count  = 0;
    prev_rv   = 1'b0;
    rv_cyc    = -1;
    hs_cyc    = -1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset          = 1'b1;
    sel            = 1'b0;
    lat            = 1;
    rr             = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    ifu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    lsu_resp_ready = 1'b1;
    m_acc          = 0;
    @(posedge clock);
    #1;

    // LAT=1, fixed priority: single IFU fetch
    do_reset();
    ifu_req_addr  = 64'h0000_0000_8000_0000;
    ifu_req_valid = 1'b1;
    run(5, 1'b0);
    chk("ifu_read_latency", 64'(rv_cyc - hs_cyc), 64'd2);
    chk("ifu_read_data", rv_data, 64'h00000413_00000297);

    // LAT=1, fixed priority: simultaneous requests
    lsu_req_addr  = 64'h0000_0000_8000_2000;
    lsu_req_wen   = 1'b0;
    ifu_req_addr  = 64'h0000_0000_8000_0040;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    gn = 0;
    gseq = '0;
    run(8, 1'b0);
    chk("rr0_grant_count", 64'(gn), 64'd2);
    chk("rr0_grant_order", 64'(gseq[1:0]), 64'b10);

    run_random(300);

    // LAT=3, round-robin: store
    sel = 1'b1;
    lat = 3;
    rr  = 1'b1;
    do_reset();
    lsu_req_addr  = 64'h0000_0000_8000_1000;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 64'h1122_3344_5566_7788;
    lsu_req_wmask = 8'h0F;
    lsu_req_valid = 1'b1;
    run(7, 1'b0);
    chk("store_wvalid_pulses", 64'(wv_count), 64'd1);
    chk("store_latency", 64'(rv_cyc - hs_cyc), 64'd4);
    chk("store_resp_data", rv_data, 64'd0);

    // round-robin contention over four transactions
    do_reset();
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 64'h0000_0000_8000_3000;
    ifu_req_addr  = 64'h0000_0000_8000_0100;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 40 && gn < 4; i++) run(1, 1'b1);
    chk("rr1_grant_count", 64'(gn), 64'd4);
    chk("rr1_grant_order", 64'(gseq[3:0]), 64'b1010);

    // response backpressure
    do_reset();
    ifu_req_addr   = 64'h0000_0000_8000_0200;
    ifu_req_valid  = 1'b1;
    ifu_resp_ready = 1'b0;
    run(1, 1'b0);
    lsu_req_addr  = 64'h0000_0000_8000_4000;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 10 && !o_ifu_resp_valid; i++) run(1, 1'b0);
    chk("bp_resp_seen", 64'(o_ifu_resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_busy", 64'(o_busy), 64'd1);
      chk("bp_lsu_ready", 64'(o_lsu_req_ready), 64'd0);
      run(1, 1'b0);
    end
    chk("bp_data_held", o_ifu_resp_data, mem_f(64'h0000_0000_8000_0200));
    ifu_resp_ready = 1'b1;
    run(1, 1'b0);
    chk("bp_idle_after_release", 64'(o_busy), 64'd0);
    run(6, 1'b0);
    chk("bp_grant_order", 64'(gseq[1:0]), 64'b01);

    // reset during a store's access phase
    do_reset();
    lsu_req_addr  = 64'h0000_0000_8000_5000;
    lsu_req_wen   = 1'b1;
    lsu_req_wdata = 64'hCAFE_F00D_0000_0001;
    lsu_req_wmask = 8'hFF;
    lsu_req_valid = 1'b1;
    run(1, 1'b0);
    chk("mr_wvalid_before", 64'(o_mem_wvalid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_wvalid_async", 64'(o_mem_wvalid), 64'd0);
    chk("mr_busy_async", 64'(o_busy), 64'd0);
    do_reset();
    run(5, 1'b0);
    chk("mr_no_stale_resp", 64'(rv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    ifu_req_addr  = 64'h0000_0000_8000_0300;
    ifu_req_valid = 1'b1;
    run(7, 1'b0);
    chk("mr_read_latency", 64'(rv_cyc - hs_cyc), 64'd4);
    chk("mr_read_data", rv_data, mem_f(64'h0000_0000_8000_0300));

    run_random(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
